// File: rtl/cla_multiword_seq_if.sv
// Operand/result bundle for the word-serial multi-precision adder.
interface cla_multiword_seq_if #(
  parameter int unsigned WORDS = 2
);
  localparam int unsigned TOT_W = 32 * WORDS;

  logic             start;
  logic             sub;
  logic             c_in;
  logic [TOT_W-1:0] a;
  logic [TOT_W-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [TOT_W-1:0] s;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, c_in, a, b,
    input  ready, busy, done, s, c_out, overflow
  );

  modport slave (
    input  start, sub, c_in, a, b,
    output ready, busy, done, s, c_out, overflow
  );
endinterface

// File: rtl/cla_multiword_seq.sv
// Word-serial multi-precision add/subtract: one 32-bit CLA stepped over WORDS
// cycles with the inter-word carry held in a register.
module cla_multiword_seq #(
  parameter int unsigned WORDS = 2
) (
  input logic               clk,
  input logic               rst_n,
  cla_multiword_seq_if.slave bus
);
  localparam int unsigned W      = 32;
  localparam int unsigned GROUPS = W / 4;
  localparam int unsigned TOT_W  = W * WORDS;
  localparam int unsigned IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       a_q [WORDS];
  logic [W-1:0]       a_d [WORDS];
  logic [W-1:0]       b_q [WORDS];
  logic [W-1:0]       b_d [WORDS];
  logic [W-1:0]       stage_q [WORDS];
  logic [W-1:0]       stage_d [WORDS];
  logic [TOT_W-1:0]   s_q, s_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [W-1:0]       add_x, add_y, add_sum;
  logic               add_cout, add_ovf;
  logic               last_word;

  // 32-bit carry-lookahead adder: 4-bit groups with group generate/propagate
  // feeding the group carry chain. Returns {overflow, carry_out, sum}.
  function automatic logic [W+1:0] cla_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         cin);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0]   c;
    logic         gg;
    logic         gp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < int'(GROUPS); k++) begin
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
         | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp = &p[4*k +: 4];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
      c[4*k+4] = gg | (gp & c[4*k]);
    end
    return {c[W] ^ c[W-1], c[W], p ^ c[W-1:0]};
  endfunction

  // Single shared adder on the currently selected word
  always_comb begin
    add_x = a_q[idx_q];
    add_y = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    {add_ovf, add_cout, add_sum} = cla_add(add_x, add_y, carry_q);
  end

  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    stage_d = stage_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          sub_d   = bus.sub;
          idx_d   = '0;
          carry_d = bus.sub ? 1'b1 : bus.c_in;
          for (int i = 0; i < int'(WORDS); i++) begin
            a_d[i] = bus.a[i*W +: W];
            b_d[i] = bus.b[i*W +: W];
          end
        end
      end
      RUN: begin
        stage_d[idx_q] = add_sum;
        carry_d        = add_cout;
        if (last_word) begin
          state_d = IDLE;
          idx_d   = '0;
          for (int i = 0; i < int'(WORDS); i++) begin
            s_d[i*W +: W] = stage_d[i];
          end
          cout_d = add_cout;
          ovf_d  = add_ovf;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      for (int i = 0; i < int'(WORDS); i++) begin
        a_q[i]     <= '0;
        b_q[i]     <= '0;
        stage_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      a_q     <= a_d;
      b_q     <= b_d;
      stage_q <= stage_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.done     = done_q;
  assign bus.s        = s_q;
  assign bus.c_out    = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: doc/cla_multiword_seq.md
# cla_multiword_seq

Word-serial multi-precision adder/subtractor controller. It sequences a single 32-bit carry-lookahead adder over `WORDS` consecutive cycles to produce a 32×`WORDS`-bit sum or difference. It chains the carry between words through a register. It sits between the integer datapath's operand registers and any consumer needing wide arithmetic (64/128-bit counters, address math) where replicating the adder is too costly.

## Interface
- `WORDS`, 2, number of 32-bit words per operand; legal range 1..8.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `start` input 1: request an operation; accepted only when `ready`=1.
- `sub` input 1: 0 = A+B+`c_in`; 1 = A−B (B inverted, initial carry forced to 1, `c_in` ignored).
- `c_in` input 1: carry into word 0 for add.
- `a` input 32×WORDS: operand A, sampled on the accept edge only.
- `b` input 32×WORDS: operand B, sampled on the accept edge only.
- `ready` output 1: controller idle, can accept `start`.
- `busy` output 1: operation in progress (equal to ~`ready`).
- `done` output 1: single-cycle pulse, result registers just updated.
- `s` output 32×WORDS: registered result of the last completed operation.
- `c_out` output 1: carry out of the top word; for subtract, 1 = no borrow (A ≥ B unsigned).
- `overflow` output 1: signed overflow of the full-width operation, from the top word's carry-in XOR carry-out.

## Operation
- Exactly one 32-bit CLA instance. Its inputs are the selected word of the latched A and the selected word of latched B (inverted when `sub`). Its carry-in is the carry register.
- State IDLE: `ready`=1. On an edge with `start`=1:
  - latch `a`, `b` and `sub`;
  - word index `idx` ← 0;
  - carry ← `sub` ? 1 : `c_in`;
  - go to RUN.
- State RUN: `ready`=0. On each edge:
  - write the adder sum for word `idx` into an internal staging register;
  - carry ← adder `c_out`;
  - `idx` ← `idx`+1.
- Final word (`idx`=WORDS−1), on that edge:
  - `s` ← {final sum word, staged lower words};
  - `c_out` ← adder carry-out;
  - `overflow` ← adder overflow;
  - `done` ← 1;
  - state ← IDLE.
- `s`, `c_out` and `overflow` change only on the final-word edge. They hold their values otherwise, including during a following operation.
- `start` while RUN is ignored; it is neither queued nor able to corrupt the latched operands.
- Changes on `a`, `b`, `sub` or `c_in` after the accept edge have no effect.
- WORDS=1: RUN lasts one cycle; behaviour is identical to a single registered 32-bit add.
- `idx` width is ceil(log2(WORDS)), minimum 1. It never exceeds WORDS−1.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state IDLE, `ready`=1, `busy`=0, `done`=0;
  - `s`=0, `c_out`=0, `overflow`=0;
  - carry=0, `idx`=0, staging register=0.
- Reset mid-RUN aborts the operation. No `done` pulse follows, and outputs return to their reset values on that edge.
- Latency: accept edge E → `done` high and result valid during the cycle after edge E+WORDS. Throughput is one operation per WORDS+1 cycles.
- `done` is high for exactly one cycle. `ready` is already 1 in that cycle, so a `start` seen with `done` is accepted, giving back-to-back operations.
- The adder path is purely combinational within a cycle; there is no multicycle path.

## Test plan
- **Carry across words.** WORDS=2, add, A=0xFFFFFFFF_FFFFFFFF, B=1, `c_in`=0 → required after 2 RUN cycles: `s`=0, `c_out`=1, `overflow`=0, one `done` pulse, `ready` rising with `done`.
- **Signed overflow.** WORDS=2, add, A=0x7FFFFFFF_FFFFFFFF, B=1 → `s`=0x80000000_00000000, `c_out`=0, `overflow`=1.
- **Subtract with borrow.** WORDS=2, sub, A=5, B=7, `c_in`=1 (ignored) → `s`=0xFFFFFFFF_FFFFFFFE, `c_out`=0, `overflow`=0. Then A=7, B=5 → `s`=2, `c_out`=1.
- **Busy protection.** Pulse `start` with new operands during RUN → ignored; first result unchanged; exactly one `done`. Hold `start` high in the `done` cycle → second operation accepted, and its `done` arrives WORDS+1 cycles after the first `done`.
- **Reset mid-run.** WORDS=4, assert `rst_n`=0 at the edge after the second RUN edge → all outputs 0, `ready`=1, no `done` for the aborted operation. A following op (A=1, B=2) → `s`=3.
- **Degenerate width.** WORDS=1, add, A=0xFFFFFFFF, B=0, `c_in`=1 → `s`=0, `c_out`=1, `done` one cycle after accept.
